// File: rtl/ff_d_univ_bank.sv
// Bank of CHANNELS independent WIDTH-bit universal registers (hold/shr/shl/load, per-channel set).
// Optional parity output PAR is enabled by defining FF_D_UNIV_BANK_PARITY_EN.
module ff_d_univ_bank #(
   parameter int WIDTH    = 4,
   parameter int CHANNELS = 2,
   parameter int CASCADE  = 0
) (
   input  logic                        CP,
   input  logic                        RD,
   input  logic [CHANNELS-1:0]         SD,
   input  logic [2*CHANNELS-1:0]       S,
   input  logic [CHANNELS*WIDTH-1:0]   D,
   input  logic [CHANNELS-1:0]         DSR,
   input  logic [CHANNELS-1:0]         DSL,
   output logic [CHANNELS*WIDTH-1:0]   Q,
`ifdef FF_D_UNIV_BANK_PARITY_EN
   output logic [CHANNELS*WIDTH-1:0]   nQ,
   output logic [CHANNELS-1:0]         PAR
`else
   output logic [CHANNELS*WIDTH-1:0]   nQ
`endif
);

   logic [CHANNELS*WIDTH-1:0] q_q, q_d;
   logic [CHANNELS-1:0]       msb, lsb;
   logic [CHANNELS-1:0]       sin_r, sin_l;

   always_comb begin
      msb = '0;
      lsb = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         msb[c] = q_q[c*WIDTH + WIDTH-1];
         lsb[c] = q_q[c*WIDTH];
      end
   end

   // In cascade mode each channel's serial input is the pre-edge edge bit of its neighbour,
   // so adjacent channels shifting together behave as one long register.
   always_comb begin
      if (CASCADE != 0) begin
         sin_r = (msb << 1) | CHANNELS'(DSR[0]);
         sin_l = (lsb >> 1) | (CHANNELS'(DSL[CHANNELS-1]) << (CHANNELS-1));
      end else begin
         sin_r = DSR;
         sin_l = DSL;
      end
   end

   always_comb begin
      q_d = q_q;
      for (int c = 0; c < CHANNELS; c++) begin
         case (S[2*c +: 2])
            2'b01:   q_d[c*WIDTH +: WIDTH] = {q_q[c*WIDTH +: WIDTH-1], sin_r[c]};
            2'b10:   q_d[c*WIDTH +: WIDTH] = {sin_l[c], q_q[c*WIDTH+1 +: WIDTH-1]};
            2'b11:   q_d[c*WIDTH +: WIDTH] = D[c*WIDTH +: WIDTH];
            default: q_d[c*WIDTH +: WIDTH] = q_q[c*WIDTH +: WIDTH];
         endcase
         if (!SD[c]) q_d[c*WIDTH +: WIDTH] = '1;
      end
      if (!RD) q_d = '0;
   end

   always_ff @(posedge CP) begin
      q_q <= q_d;
   end

   assign Q  = q_q;
   assign nQ = ~q_q;

`ifdef FF_D_UNIV_BANK_PARITY_EN
   always_comb begin
      PAR = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         PAR[c] = ^q_q[c*WIDTH +: WIDTH];
      end
   end
`endif

endmodule
